// File: rtl/cfu_dequantizer.sv
// cfu_dequantizer: unpacks one 32-bit word of signed int8 activations and emits one
// dequantized int32 lane per valid/ready handshake:
//   out = sat32(((lane - zero_point) * mul + round) >>> shift)
// where round = 1 << (shift - 1) for shift > 0, so halves round toward +inf.
module cfu_dequantizer #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned PROD_W = 42
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [2:0]  in_lanes,
  input  logic [7:0]  zero_point,
  input  logic [31:0] mul,
  input  logic [4:0]  shift,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy
);

  localparam int unsigned IdxW = $clog2(LANES);
  localparam int unsigned CntW = IdxW + 1;

  // int32 saturation bounds, sign-extended to the product width
  localparam logic signed [PROD_W-1:0] SatMax = {{(PROD_W-31){1'b0}}, {31{1'b1}}};
  localparam logic signed [PROD_W-1:0] SatMin = {{(PROD_W-31){1'b1}}, {31{1'b0}}};

  typedef enum logic [1:0] {StIdle, StMul, StOut} state_e;

  state_e                    state_q, state_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_last_q, out_last_d;
  logic [31:0]               out_data_q, out_data_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [CntW-1:0]           n_q, n_d;
  logic [31:0]               word_q, word_d;
  logic [7:0]                zp_q, zp_d;
  logic [31:0]               mul_q, mul_d;
  logic [4:0]                shift_q, shift_d;
  logic signed [PROD_W-1:0]  prod_q, prod_d;

  logic [7:0]                lane;
  logic [8:0]                diff;
  logic signed [PROD_W-1:0]  diff_ext, mul_ext, rnd, sum, shifted;
  logic [31:0]               sat;
  logic                      is_last;

  // Datapath: current lane product, then rounding shift and int32 saturation of prod_q
  always_comb begin
    lane     = word_q[8*idx_q +: 8];
    // 9-bit difference cannot wrap: int8 - int8 spans -255..255
    diff     = {lane[7], lane} - {zp_q[7], zp_q};
    diff_ext = {{(PROD_W-9){diff[8]}}, diff};
    mul_ext  = {{(PROD_W-32){mul_q[31]}}, mul_q};
    rnd      = (shift_q != 5'd0) ? (PROD_W'(1) << (shift_q - 5'd1)) : '0;
    sum      = prod_q + rnd;
    shifted  = sum >>> shift_q;
    if (shifted > SatMax) begin
      sat = 32'h7FFF_FFFF;
    end else if (shifted < SatMin) begin
      sat = 32'h8000_0000;
    end else begin
      sat = shifted[31:0];
    end
    is_last  = (CntW'(idx_q) == (n_q - CntW'(1)));
  end

  // Next-state and register-load decisions for the IDLE -> MUL -> OUT lane loop
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    idx_d       = idx_q;
    n_d         = n_q;
    word_d      = word_q;
    zp_d        = zp_q;
    mul_d       = mul_q;
    shift_d     = shift_q;
    prod_d      = prod_q;
    unique case (state_q)
      StIdle: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          word_d     = in_data;
          // zero or out-of-range lane counts mean a full word
          n_d        = (in_lanes == 3'd0 || in_lanes > 3'(LANES)) ? CntW'(LANES)
                                                                  : CntW'(in_lanes);
          zp_d       = zero_point;
          mul_d      = mul;
          shift_d    = shift;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = StMul;
        end
      end
      StMul: begin
        prod_d  = diff_ext * mul_ext;
        state_d = StOut;
      end
      StOut: begin
        if (!out_valid_q) begin
          out_data_d  = sat;
          out_valid_d = 1'b1;
          out_last_d  = is_last;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            out_last_d = 1'b0;
            in_ready_d = 1'b1;
            state_d    = StIdle;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StMul;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      idx_q       <= '0;
      n_q         <= '0;
      word_q      <= '0;
      zp_q        <= '0;
      mul_q       <= '0;
      shift_q     <= '0;
      prod_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      idx_q       <= idx_d;
      n_q         <= n_d;
      word_q      <= word_d;
      zp_q        <= zp_d;
      mul_q       <= mul_d;
      shift_q     <= shift_d;
      prod_q      <= prod_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != StIdle);

endmodule
